// File: rtl/lbp_img_host.sv
// lbp_img_host: image/result memory responder for the gray-read / LBP-write protocol.
// Optional LBP_CHECKSUM_EN adds the lbp_sum running checksum of accepted result writes.
module lbp_img_host #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [15:0]   wr_count,
    output logic          proto_err,
    output logic          done
`ifdef LBP_CHECKSUM_EN
    ,
    output logic [15:0]   lbp_sum
`endif
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

    state_t        state;
    logic [AW-1:0] ld_cnt;
    logic [7:0]    gray_hold;
    logic [7:0]    img [NPIX];
    logic [7:0]    res [NPIX];
    logic          ld_xfer;
    logic          wr_acc;

    assign ld_xfer   = ld_valid && ld_ready && state == LOAD;
    assign wr_acc    = lbp_valid && state == SERVE;
    // Reads are combinational so the initiator can sample one edge after the address.
    assign gray_data = state == LOAD ? 8'h00 : gray_req ? img[gray_addr] : gray_hold;

    // Image and result RAMs are never cleared; reset only invalidates the loaded image.
    always_ff @(posedge clk) begin
        if (ld_xfer) img[ld_cnt] <= ld_data;
        if (wr_acc) res[lbp_addr] <= lbp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            ld_cnt     <= '0;
            ld_ready   <= 1'b1;
            gray_ready <= 1'b0;
            gray_hold  <= 8'h00;
            wr_count   <= 16'h0000;
            proto_err  <= 1'b0;
            done       <= 1'b0;
            rd_data    <= 8'h00;
`ifdef LBP_CHECKSUM_EN
            lbp_sum    <= 16'h0000;
`endif
        end else begin
            rd_data <= res[rd_addr];
            if (gray_req && state != LOAD) gray_hold <= img[gray_addr];
            case (state)
                LOAD: begin
                    if (lbp_valid || gray_req) proto_err <= 1'b1;
                    if (ld_xfer) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == LAST) begin
                            state      <= SERVE;
                            ld_ready   <= 1'b0;
                            gray_ready <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (lbp_valid) begin
                        wr_count <= wr_count + (wr_count != 16'hFFFF ? 16'd1 : 16'd0);
`ifdef LBP_CHECKSUM_EN
                        lbp_sum  <= lbp_sum + {8'h00, lbp_data};
`endif
                    end
                    if (finish) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (lbp_valid) proto_err <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_lbp_img_host.sv
// tb_lbp_img_host: randomized self-checking bench for lbp_img_host against an array-based model.
module tb_lbp_img_host;
    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset, ld_valid, gray_req, lbp_valid, finish;
    logic [7:0]  ld_data, lbp_data;
    logic [13:0] gray_addr, lbp_addr, rd_addr;
    logic        ld_ready, gray_ready, proto_err, done;
    logic [7:0]  gray_data, rd_data;
    logic [15:0] wr_count;
`ifdef LBP_CHECKSUM_EN
    logic [15:0] lbp_sum;
`endif

    logic [7:0]  img_m [N];
    logic [7:0]  res_m [N];
    bit          res_v [N];
    int          wc_m;
    int          sum_m;
    int          checks = 0;
    int          failures = 0;

    lbp_img_host dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count), .proto_err(proto_err),
        .done(done)
`ifdef LBP_CHECKSUM_EN
        , .lbp_sum(lbp_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wc_m = 0;
        sum_m = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got %b exp 1", ld_ready); end
        if (gray_ready !== 1'b0) begin failures++; $display("FAIL rst_gray_ready got %b exp 0", gray_ready); end
        if (wr_count !== 16'h0) begin failures++; $display("FAIL rst_wr_count got %h exp 0", wr_count); end
        if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got %b exp 0", proto_err); end
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %b exp 0", done); end
        if (gray_data !== 8'h00) begin failures++; $display("FAIL rst_gray_data got %h exp 0", gray_data); end
    endtask

    task automatic test_load_err();
        gray_req = 1'b1;
        gray_addr = 14'($urandom);
        #1;
        checks++;
        if (gray_data !== 8'h00) begin failures++; $display("FAIL load_gray_zero got %h exp 0", gray_data); end
        tick();
        gray_req = 1'b0;
        checks++;
        if (proto_err !== 1'b1) begin failures++; $display("FAIL load_gray_err got %b exp 1", proto_err); end
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin failures++; $display("FAIL err_cleared got %b exp 0", proto_err); end
        lbp_valid = 1'b1;
        lbp_addr = 14'h0081;
        lbp_data = 8'hA5;
        tick();
        lbp_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks += 2;
        if (wr_count !== 16'h0) begin failures++; $display("FAIL load_wr_ignored got %h exp 0", wr_count); end
        if (proto_err !== 1'b1) begin failures++; $display("FAIL load_wr_err_sticky got %b exp 1", proto_err); end
    endtask

    task automatic test_load();
        int a = 0;
        int cyc = 0;
        bit seen_last = 0;
        do_reset();
        while (a < N && cyc < 40000) begin
            ld_valid = ($urandom_range(0, 7) != 0);
            ld_data = 8'($urandom);
            if (a == N - 1 && !seen_last) begin
                seen_last = 1;
                checks++;
                if (gray_ready !== 1'b0 || ld_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL load_before_last got gr=%b lr=%b exp gr=0 lr=1", gray_ready, ld_ready);
                end
            end
            if (ld_valid) img_m[a] = ld_data;
            tick();
            if (ld_valid) a++;
            cyc++;
        end
        ld_valid = 1'b0;
        checks += 3;
        if (a != N) begin failures++; $display("FAIL load_timeout got %0d exp %0d", a, N); end
        if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_end_ld_ready got %b exp 0", ld_ready); end
        if (gray_ready !== 1'b1) begin failures++; $display("FAIL load_end_gray_ready got %b exp 1", gray_ready); end
    endtask

    task automatic test_gray();
        logic [13:0] ga;
        gray_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ga = (i == 23) ? 14'h0081 : 14'($urandom);
            gray_addr = ga;
            #1;
            checks++;
            if (gray_data !== img_m[ga]) begin failures++; $display("FAIL gray_read addr %h got %h exp %h", ga, gray_data, img_m[ga]); end
        end
        tick();
        gray_req = 1'b0;
        gray_addr = 14'($urandom);
        #1;
        checks++;
        if (gray_data !== img_m[14'h0081]) begin failures++; $display("FAIL gray_hold got %h exp %h", gray_data, img_m[14'h0081]); end
        tick();
        checks += 2;
        if (gray_data !== img_m[14'h0081]) begin failures++; $display("FAIL gray_hold2 got %h exp %h", gray_data, img_m[14'h0081]); end
        if (proto_err !== 1'b0) begin failures++; $display("FAIL serve_no_err got %b exp 0", proto_err); end
    endtask

    task automatic write1(input logic [13:0] a, input logic [7:0] d, input logic fin);
        lbp_valid = 1'b1;
        lbp_addr = a;
        lbp_data = d;
        finish = fin;
        tick();
        lbp_valid = 1'b0;
        finish = 1'b0;
        res_m[a] = d;
        res_v[a] = 1;
        wc_m++;
        sum_m = (sum_m + d) & 16'hFFFF;
    endtask

    task automatic test_write();
        logic [13:0] a;
        logic [13:0] prev;
        write1(14'h0081, 8'hA5, 1'b0);
        rd_addr = 14'h0081;
        tick();
        checks += 2;
        if (wr_count !== 16'd1) begin failures++; $display("FAIL wr_first_count got %0d exp 1", wr_count); end
        if (rd_data !== 8'hA5) begin failures++; $display("FAIL wr_first_rd got %h exp a5", rd_data); end
        prev = 14'h0081;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? prev : {7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))};
            prev = a;
            write1(a, 8'($urandom), 1'b0);
        end
        checks++;
        if (wr_count !== 16'(wc_m)) begin failures++; $display("FAIL wr_count got %0d exp %0d", wr_count, wc_m); end
        for (int i = 0; i < N; i++) begin
            if (res_v[i] && $urandom_range(0, 1) == 0) begin
                rd_addr = 14'(i);
                tick();
                checks++;
                if (rd_data !== res_m[i]) begin failures++; $display("FAIL wr_readback addr %h got %h exp %h", i, rd_data, res_m[i]); end
            end
        end
`ifdef LBP_CHECKSUM_EN
        checks++;
        if (lbp_sum !== 16'(sum_m)) begin failures++; $display("FAIL wr_sum got %h exp %h", lbp_sum, 16'(sum_m)); end
`endif
    endtask

    task automatic test_reset_serve();
        reset = 1'b1;
        gray_req = 1'b1;
        tick();
        checks += 6;
        if (gray_ready !== 1'b0) begin failures++; $display("FAIL rs_gray_ready got %b exp 0", gray_ready); end
        if (ld_ready !== 1'b1) begin failures++; $display("FAIL rs_ld_ready got %b exp 1", ld_ready); end
        if (wr_count !== 16'h0) begin failures++; $display("FAIL rs_wr_count got %h exp 0", wr_count); end
        if (done !== 1'b0) begin failures++; $display("FAIL rs_done got %b exp 0", done); end
        if (proto_err !== 1'b0) begin failures++; $display("FAIL rs_proto_err got %b exp 0", proto_err); end
        if (gray_data !== 8'h00) begin failures++; $display("FAIL rs_gray_data got %h exp 0", gray_data); end
        gray_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_full_run();
        int k = 0;
        logic [7:0] d;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                d = (k == 0) ? 8'hFF : (k == 1) ? 8'h02 : 8'($urandom);
                if (k == 15875) begin
                    checks++;
                    if (done !== 1'b0) begin failures++; $display("FAIL full_done_early got %b exp 0", done); end
                end
                write1({7'(r), 7'(c)}, d, k == 15875);
                k++;
`ifdef LBP_CHECKSUM_EN
                if (k == 2) begin
                    checks++;
                    if (lbp_sum !== 16'h0101) begin failures++; $display("FAIL sum_ff_02 got %h exp 0101", lbp_sum); end
                end
`endif
            end
        end
        checks += 3;
        if (done !== 1'b1) begin failures++; $display("FAIL full_done got %b exp 1", done); end
        if (wr_count !== 16'd15876) begin failures++; $display("FAIL full_count got %0d exp 15876", wr_count); end
        if (proto_err !== 1'b0) begin failures++; $display("FAIL full_no_err got %b exp 0", proto_err); end
`ifdef LBP_CHECKSUM_EN
        checks++;
        if (lbp_sum !== 16'(sum_m)) begin failures++; $display("FAIL full_sum got %h exp %h", lbp_sum, 16'(sum_m)); end
`endif
        lbp_valid = 1'b1;
        lbp_addr = 14'h0081;
        lbp_data = ~res_m[14'h0081];
        tick();
        lbp_valid = 1'b0;
        rd_addr = 14'h0081;
        tick();
        checks += 5;
        if (proto_err !== 1'b1) begin failures++; $display("FAIL done_wr_err got %b exp 1", proto_err); end
        if (wr_count !== 16'd15876) begin failures++; $display("FAIL done_wr_count got %0d exp 15876", wr_count); end
        if (rd_data !== res_m[14'h0081]) begin failures++; $display("FAIL done_wr_ignored got %h exp %h", rd_data, res_m[14'h0081]); end
        if (gray_ready !== 1'b1) begin failures++; $display("FAIL done_gray_ready got %b exp 1", gray_ready); end
        if (done !== 1'b1) begin failures++; $display("FAIL done_held got %b exp 1", done); end
        gray_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gray_addr = 14'($urandom);
            #1;
            checks++;
            if (gray_data !== img_m[gray_addr]) begin failures++; $display("FAIL done_gray addr %h got %h exp %h", gray_addr, gray_data, img_m[gray_addr]); end
        end
        gray_req = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd_addr = {7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))};
            tick();
            checks++;
            if (rd_data !== res_m[rd_addr]) begin failures++; $display("FAIL full_readback addr %h got %h exp %h", rd_addr, rd_data, res_m[rd_addr]); end
        end
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; gray_req = 1'b0; gray_addr = '0;
        lbp_valid = 1'b0; lbp_addr = '0; lbp_data = 8'h00; finish = 1'b0; rd_addr = '0;
        test_reset();
        test_load_err();
        test_load();
        test_gray();
        test_write();
        test_reset_serve();
        test_load();
        test_full_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
